// File: rtl/vout_pkg.sv
// Shared definitions for the vout output-conditioning plugins.
// Holds the code/setpoint widths, the ramp state encoding and the
// saturating converter from a signed host level to an 8-bit pot code.
package vout_pkg;

  localparam int VALUE_W = 8;
  localparam int SP_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_e;

  // Clamp a signed 32-bit level into the 0..255 pot code range.
  function automatic logic [VALUE_W-1:0] sat_u8(input logic signed [SP_W-1:0] s);
    logic [VALUE_W-1:0] r;
    if (s < 32'sd0) begin
      r = 8'd0;
    end else if (s > 32'sd255) begin
      r = 8'd255;
    end else begin
      r = s[VALUE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/vout_spipoti_ramp_tick_div.sv
// tick_div: free-running tick generator shared by the vout plugins.
// A down-counter starts at DIV-1; tick is high for the one cycle in which
// the count is 0, after which the counter reloads DIV-1. DIV = 1 gives a
// tick on every cycle.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset (reloads the counter)
//   tick - registered one-cycle strobe, once every DIV clocks
module tick_div #(
  parameter int DIV = 400000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
  // When the counter reloads, the tick for the following cycle is only
  // high if the reload value itself is 0.
  localparam logic             TICK_ON_RELOAD = (DIV == 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Counter and registered tick; tick_r always mirrors (cnt_r == 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= RELOAD;
      tick_r <= TICK_ON_RELOAD;
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      cnt_r  <= RELOAD;
      tick_r <= TICK_ON_RELOAD;
    end else begin
      cnt_r  <= cnt_r - CNT_W'(1);
      tick_r <= (cnt_r == CNT_W'(1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/vout_spipoti_ramp.sv
// vout_spipoti_ramp: conditioning stage ahead of the SPI digital-pot driver.
// Scales and saturates a signed host setpoint into an 8-bit pot code, then
// slew-limits the output so it moves by at most STEP codes per tick, with
// one tick every STEP_DIV clocks.
// Ports:
//   clk            - system clock
//   rst            - synchronous, active-high reset
//   setpoint       - signed requested level, host units
//   setpoint_valid - one-cycle strobe capturing setpoint
//   enable         - high: follow request; low: ramp to SAFE_VALUE
//   value          - registered pot code to the SPI driver
//   changed        - one-cycle pulse in the cycle value takes a new code
//   at_target      - registered (value == effective target)
module vout_spipoti_ramp
  import vout_pkg::*;
#(
  parameter int SHIFT      = 0,
  parameter int STEP       = 8,
  parameter int STEP_DIV   = 400000,
  parameter int INIT_VALUE = 0,
  parameter int SAFE_VALUE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SP_W-1:0]   setpoint,
  input  logic              setpoint_valid,
  input  logic              enable,
  output logic [VALUE_W-1:0] value,
  output logic              changed,
  output logic              at_target
);

  localparam logic [VALUE_W-1:0] STEP_C = VALUE_W'(STEP);
  localparam logic [VALUE_W-1:0] INIT_C = VALUE_W'(INIT_VALUE);
  localparam logic [VALUE_W-1:0] SAFE_C = VALUE_W'(SAFE_VALUE);

  logic                     tick_s;
  logic signed [SP_W-1:0]   sp_scaled_s;
  logic [VALUE_W-1:0]       request_r;
  logic [VALUE_W-1:0]       target_s;
  logic [VALUE_W-1:0]       value_r;
  logic [VALUE_W-1:0]       value_next_s;
  logic                     changed_r;
  logic                     changed_next_s;
  logic                     at_target_r;
  ramp_state_e              state_r;
  ramp_state_e              state_next_s;
  logic                     go_up_s;
  logic                     go_down_s;
  logic [VALUE_W:0]         sum_s;
  logic signed [VALUE_W:0]  diff_s;
  logic [VALUE_W-1:0]       up_val_s;
  logic [VALUE_W-1:0]       dn_val_s;

  tick_div #(
    .DIV (STEP_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign sp_scaled_s = $signed(setpoint) >>> SHIFT;

  // Request register: latches the scaled, saturated setpoint on each strobe,
  // regardless of enable, so a write while disabled applies on re-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      request_r <= INIT_C;
    end else if (setpoint_valid) begin
      request_r <= sat_u8(sp_scaled_s);
    end else begin
      request_r <= request_r;
    end
  end

  assign target_s  = enable ? request_r : SAFE_C;
  assign go_up_s   = (target_s > value_r);
  assign go_down_s = (target_s < value_r);

  // Candidate codes are formed one bit wider than the code so that an
  // upward step cannot wrap past 255 and a downward step cannot wrap below 0.
  assign sum_s    = {1'b0, value_r} + {1'b0, STEP_C};
  assign diff_s   = $signed({1'b0, value_r}) - $signed({1'b0, STEP_C});
  assign up_val_s = (sum_s > {1'b0, target_s}) ? target_s : sum_s[VALUE_W-1:0];
  assign dn_val_s = (diff_s < $signed({1'b0, target_s})) ? target_s : diff_s[VALUE_W-1:0];

  // Ramp direction tracking and slew-limited step on each tick.
  always_comb begin
    state_next_s   = state_r;
    value_next_s   = value_r;
    changed_next_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (go_up_s) begin
          state_next_s = UP;
        end else if (go_down_s) begin
          state_next_s = DOWN;
        end else begin
          state_next_s = IDLE;
        end
      end
      UP: begin
        if (go_down_s) begin
          state_next_s = DOWN;
        end else begin
          state_next_s = UP;
        end
      end
      DOWN: begin
        if (go_up_s) begin
          state_next_s = UP;
        end else begin
          state_next_s = DOWN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // The step direction follows the live comparison, so a reversed target
    // is honoured on the very next tick without overshooting.
    if (tick_s && go_up_s) begin
      value_next_s   = up_val_s;
      changed_next_s = 1'b1;
    end else if (tick_s && go_down_s) begin
      value_next_s   = dn_val_s;
      changed_next_s = 1'b1;
    end else begin
      value_next_s   = value_r;
      changed_next_s = 1'b0;
    end

    if (value_next_s == target_s) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      value_r     <= INIT_C;
      changed_r   <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      value_r     <= value_next_s;
      changed_r   <= changed_next_s;
      at_target_r <= (value_next_s == target_s);
    end
  end

  assign value     = value_r;
  assign changed   = changed_r;
  assign at_target = at_target_r;

endmodule

// File: tb/tb_vout_spipoti_ramp.sv
// Bench for vout_spipoti_ramp. Two instances share the stimulus:
//   dut0: SHIFT=0, STEP=16, STEP_DIV=4, INIT=0,  SAFE=0
//   dut1: SHIFT=4, STEP=255 (jump), STEP_DIV=1, INIT=37, SAFE=200
// A reference model tracks each instance from the behavioural rules; the
// scenario tasks additionally check literal expected sequences.
module tb_vout_spipoti_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] setpoint = 32'd0;
  logic        setpoint_valid = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  dv [2];
  logic        dc [2];
  logic        da [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vout_spipoti_ramp #(
    .SHIFT(0), .STEP(16), .STEP_DIV(4), .INIT_VALUE(0), .SAFE_VALUE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .setpoint(setpoint), .setpoint_valid(setpoint_valid),
    .enable(enable), .value(dv[0]), .changed(dc[0]), .at_target(da[0])
  );

  vout_spipoti_ramp #(
    .SHIFT(4), .STEP(255), .STEP_DIV(1), .INIT_VALUE(37), .SAFE_VALUE(200)
  ) dut1 (
    .clk(clk), .rst(rst), .setpoint(setpoint), .setpoint_valid(setpoint_valid),
    .enable(enable), .value(dv[1]), .changed(dc[1]), .at_target(da[1])
  );

  function automatic int shift_of(input int i); return (i == 0) ? 0 : 4; endfunction
  function automatic int step_of(input int i); return (i == 0) ? 16 : 255; endfunction
  function automatic int div_of(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int init_of(input int i); return (i == 0) ? 0 : 37; endfunction
  function automatic int safe_of(input int i); return (i == 0) ? 0 : 200; endfunction

  function automatic int sat_ref(input int s);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // Reference model state
  logic [7:0] m_val [2];
  logic [7:0] m_req [2];
  logic       m_chg [2];
  logic       m_at  [2];
  int         m_k;   // clock edges since reset released

  always @(posedge clk) begin : ref_model
    automatic int t;
    automatic int v;
    if (rst) begin
      m_k <= 0;
      for (int i = 0; i < 2; i++) begin
        m_val[i] <= 8'(init_of(i));
        m_req[i] <= 8'(init_of(i));
        m_chg[i] <= 1'b0;
        m_at[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t = enable ? int'(m_req[i]) : safe_of(i);
        v = int'(m_val[i]);
        if ((m_k % div_of(i)) == div_of(i) - 1) begin
          if (v < t) v = (v + step_of(i) > t) ? t : v + step_of(i);
          else if (v > t) v = (v - step_of(i) < t) ? t : v - step_of(i);
        end
        m_chg[i] <= (v != int'(m_val[i]));
        m_val[i] <= 8'(v);
        m_at[i]  <= (v == t);
        if (setpoint_valid) m_req[i] <= 8'(sat_ref($signed(setpoint) >>> shift_of(i)));
      end
      m_k <= m_k + 1;
    end
  end

  task automatic drive_sp(input logic [31:0] v);
    setpoint       = v;
    setpoint_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; setpoint_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (dv[0] !== 8'd0 || dc[0] !== 1'b0 || da[0] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state: value=%0d changed=%b at_target=%b, want 0 0 1", dv[0], dc[0], da[0]);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL reset_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
    end
  endtask

  task automatic test_ramp_up();
    int seen[$];
    int exp_seq[7] = '{16, 32, 48, 64, 80, 96, 100};
    drive_sp(32'd100);
    repeat (40) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL ramp_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dc[0] === 1'b1) seen.push_back(int'(dv[0]));
    end
    total++;
    if (seen.size() != 7) begin
      bad++;
      $display("FAIL ramp_pulses: got %0d changed pulses, want 7", seen.size());
    end
    for (int j = 0; j < 7 && j < seen.size(); j++) begin
      total++;
      if (seen[j] != exp_seq[j]) begin
        bad++;
        $display("FAIL ramp_seq[%0d]: got %0d want %0d", j, seen[j], exp_seq[j]);
      end
    end
    repeat (12) begin
      @(negedge clk);
      total++;
      if (dc[0] !== 1'b0 || da[0] !== 1'b1 || dv[0] !== 8'd100) begin
        bad++;
        $display("FAIL ramp_settled: value=%0d changed=%b at_target=%b, want 100 0 1", dv[0], dc[0], da[0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sp_vals [4] = '{32'hFFFF_FFFB, 32'd1000, 32'h0000_0A00, 32'd100};
    int          runs    [4] = '{40, 80, 12, 60};
    int          exp0    [4] = '{0, 255, 255, 100};
    int          exp1    [4] = '{0, 62, 160, 6};
    for (int s = 0; s < 4; s++) begin
      drive_sp(sp_vals[s]);
      for (int c = 0; c < runs[s]; c++) begin
        @(negedge clk);
        setpoint_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
          total++;
          if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
            bad++;
            $display("FAIL sat_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
          end
        end
      end
      total++;
      if (int'(dv[0]) != exp0[s] || int'(dv[1]) != exp1[s]) begin
        bad++;
        $display("FAIL sat_case%0d: dut0=%0d dut1=%0d, want %0d %0d", s, dv[0], dv[1], exp0[s], exp1[s]);
      end
    end
  endtask

  task automatic test_enable();
    int seen[$];
    int exp_dn[7] = '{84, 68, 52, 36, 20, 4, 0};
    enable = 1'b0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL enable_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dc[0] === 1'b1) seen.push_back(int'(dv[0]));
    end
    total++;
    if (seen.size() != 7) begin
      bad++;
      $display("FAIL safe_pulses: got %0d pulses, want 7", seen.size());
    end
    for (int j = 0; j < 7 && j < seen.size(); j++) begin
      total++;
      if (seen[j] != exp_dn[j]) begin
        bad++;
        $display("FAIL safe_seq[%0d]: got %0d want %0d", j, seen[j], exp_dn[j]);
      end
    end
    drive_sp(32'd200);
    repeat (12) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      total++;
      if (dv[0] !== 8'd0 || dc[0] !== 1'b0 || dv[1] !== 8'd200) begin
        bad++;
        $display("FAIL disabled_hold: dut0=%0d changed=%b dut1=%0d, want 0 0 200", dv[0], dc[0], dv[1]);
      end
    end
    enable = 1'b1;
    seen.delete();
    repeat (60) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL reenable_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dc[0] === 1'b1) seen.push_back(int'(dv[0]));
    end
    total++;
    if (seen.size() != 13 || seen[0] != 16 || dv[0] !== 8'd200 || dv[1] !== 8'd12) begin
      bad++;
      $display("FAIL reenable_ramp: pulses=%0d final0=%0d final1=%0d, want 13 200 12", seen.size(), dv[0], dv[1]);
    end
  endtask

  task automatic test_simultaneous();
    logic ok;
    drive_sp(32'd24);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL simul_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dc[0] === 1'b1 && dv[0] === 8'd168) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL simul_reach168: value=%0d, timed out", dv[0]); end
    // Advance until the next rising edge carries a tick for dut0.
    for (int c = 0; c < 8 && (m_k % 4) != 3; c++) @(negedge clk);
    drive_sp(32'd250);
    @(negedge clk);
    setpoint_valid = 1'b0;
    total++;
    if (dv[0] !== 8'd152 || dc[0] !== 1'b1) begin
      bad++;
      $display("FAIL simul_old_target: value=%0d changed=%b, want 152 1", dv[0], dc[0]);
    end
    drive_sp(32'd24);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL simul2_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dv[0] === 8'd24) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL simul_reach24: value=%0d, timed out", dv[0]); end
  endtask

  task automatic test_reversal();
    int seen[$];
    int exp_rev[5] = '{104, 88, 72, 56, 50};
    logic ok;
    drive_sp(32'd200);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      if (dc[0] === 1'b1 && dv[0] === 8'd120) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rev_reach120: value=%0d, timed out", dv[0]); end
    drive_sp(32'd50);
    repeat (40) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL rev_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if (dc[0] === 1'b1) seen.push_back(int'(dv[0]));
    end
    total++;
    if (seen.size() != 5) begin
      bad++;
      $display("FAIL rev_pulses: got %0d pulses, want 5", seen.size());
    end
    for (int j = 0; j < 5 && j < seen.size(); j++) begin
      total++;
      if (seen[j] != exp_rev[j]) begin
        bad++;
        $display("FAIL rev_seq[%0d]: got %0d want %0d", j, seen[j], exp_rev[j]);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic ok;
    drive_sp(32'd0);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      if (dv[0] === 8'd0) ok = 1'b1;
    end
    drive_sp(32'd200);
    for (int c = 0; c < 60 && ok; c++) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      if (dc[0] === 1'b1 && dv[0] === 8'd64) ok = 1'b0;
    end
    total++;
    if (ok) begin bad++; $display("FAIL rstmid_reach64: value=%0d, timed out", dv[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (dv[0] !== 8'd0 || dc[0] !== 1'b0 || da[0] !== 1'b1 || dv[1] !== 8'd37) begin
      bad++;
      $display("FAIL rstmid_state: value=%0d changed=%b at_target=%b dut1=%0d, want 0 0 1 37", dv[0], dc[0], da[0], dv[1]);
    end
    repeat (30) begin
      @(negedge clk);
      total++;
      if (dv[0] !== 8'd0 || dc[0] !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_hold: value=%0d changed=%b, want 0 0", dv[0], dc[0]);
      end
    end
    drive_sp(32'd48);
    repeat (20) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL rstmid_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
    end
    total++;
    if (dv[0] !== 8'd48) begin bad++; $display("FAIL rstmid_resume: value=%0d want 48", dv[0]); end
  endtask

  task automatic test_random();
    repeat (600) begin
      @(negedge clk);
      setpoint_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv[i] !== m_val[i] || dc[i] !== m_chg[i] || da[i] !== m_at[i]) begin
          bad++;
          $display("FAIL random_model dut%0d: got %0d/%b/%b want %0d/%b/%b", i, dv[i], dc[i], da[i], m_val[i], m_chg[i], m_at[i]);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       drive_sp($urandom());
          1:       drive_sp(32'($urandom_range(0, 255)));
          2:       drive_sp(32'($urandom_range(0, 4000)));
          default: drive_sp(32'hFFFF_FFFF - 32'($urandom_range(0, 100)));
        endcase
      end
      if ($urandom_range(0, 31) == 0) enable = ~enable;
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturation();
    test_enable();
    test_simultaneous();
    test_reversal();
    test_reset_mid_ramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
